seven_segment_scan_decoder: RTL

//  Receive side of the 4-digit multiplexed seven-segment interface. Samples the

---
 rtl/seven_segment_scan_decoder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/seven_segment_scan_decoder.sv
// Receive side of a 4-digit multiplexed seven-segment scan: samples each settled
// digit, decodes it back to BCD and rebuilds the displayed decimal number.
module seven_segment_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  Anode,
    input  logic [6:0]  LED_out,
    output logic [15:0] digits,
    output logic [13:0] num,
    output logic        num_valid,
    output logic        frame_error
);

    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    anode_q, anode_p_q;
    logic [6:0]    led_q, led_p_q;
    logic [3:0]    mask_q, mask_d;
    logic [3:0]    bad_q, bad_d;
    logic [15:0]   digits_q, digits_d;
    logic [13:0]   num_q, num_d;
    logic          num_valid_q, num_valid_d;
    logic          frame_error_q, frame_error_d;

    logic          changed;
    logic          sample;
    logic [4:0]    dec;
    logic [3:0]    mask_n, bad_n;
    logic [15:0]   digits_n;

    function automatic logic legal_anode(input logic [3:0] a);
        return (a == 4'b0111) || (a == 4'b1011) || (a == 4'b1101) || (a == 4'b1110);
    endfunction

    // Returns {valid, bcd}.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'b0000001: return {1'b1, 4'd0};
            7'b1001111: return {1'b1, 4'd1};
            7'b0010010: return {1'b1, 4'd2};
            7'b0000110: return {1'b1, 4'd3};
            7'b1001100: return {1'b1, 4'd4};
            7'b0100100: return {1'b1, 4'd5};
            7'b0100000: return {1'b1, 4'd6};
            7'b0001111: return {1'b1, 4'd7};
            7'b0000000: return {1'b1, 4'd8};
            7'b0000100: return {1'b1, 4'd9};
            default:    return 5'b0_0000;
        endcase
    endfunction

    assign changed = {anode_q, led_q} != {anode_p_q, led_p_q};
    assign dec     = decode_seg(led_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sample  = 1'b0;
        case (state_q)
            IDLE: begin
                if (legal_anode(anode_q)) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_ONE;
                end
            end
            SETTLE: begin
                if (changed) begin
                    state_d = legal_anode(anode_q) ? SETTLE : IDLE;
                    cnt_d   = legal_anode(anode_q) ? CNT_ONE : '0;
                end else if (cnt_q == CNT_MAX - CNT_ONE) begin
                    sample  = 1'b1;
                    state_d = HOLD;
                    cnt_d   = CNT_MAX;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (changed) begin
                    state_d = legal_anode(anode_q) ? SETTLE : IDLE;
                    cnt_d   = legal_anode(anode_q) ? CNT_ONE : '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        mask_n        = mask_q;
        bad_n         = bad_q;
        digits_n      = digits_q;
        mask_d        = mask_q;
        bad_d         = bad_q;
        digits_d      = digits_q;
        num_d         = num_q;
        num_valid_d   = 1'b0;
        frame_error_d = 1'b0;
        if (sample) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (!anode_q[i]) begin
                    mask_n[i] = 1'b1;
                    bad_n[i]  = ~dec[4];
                    if (dec[4]) digits_n[4*i +: 4] = dec[3:0];
                end
            end
        end
        digits_d = digits_n;
        // Completion is resolved against the post-sample mask so the result is
        // registered on the same edge that captures the last digit.
        if (mask_n == 4'b1111) begin
            mask_d = '0;
            bad_d  = '0;
            if (bad_n == 4'b0000) begin
                num_d = {10'd0, digits_n[15:12]} * 14'd1000
                      + {10'd0, digits_n[11:8]}  * 14'd100
                      + {10'd0, digits_n[7:4]}   * 14'd10
                      + {10'd0, digits_n[3:0]};
                num_valid_d = 1'b1;
            end else begin
                frame_error_d = 1'b1;
            end
        end else begin
            mask_d = mask_n;
            bad_d  = bad_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            anode_q       <= '1;
            anode_p_q     <= '1;
            led_q         <= '1;
            led_p_q       <= '1;
            mask_q        <= '0;
            bad_q         <= '0;
            digits_q      <= '0;
            num_q         <= '0;
            num_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            anode_q       <= Anode;
            anode_p_q     <= anode_q;
            led_q         <= LED_out;
            led_p_q       <= led_q;
            mask_q        <= mask_d;
            bad_q         <= bad_d;
            digits_q      <= digits_d;
            num_q         <= num_d;
            num_valid_q   <= num_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign digits      = digits_q;
    assign num         = num_q;
    assign num_valid   = num_valid_q;
    assign frame_error = frame_error_q;

endmodule
